// File: rtl/alu_cmd_seq_if.sv
// alu_cmd_seq_if: command, downstream-ALU and result signals of alu_cmd_seq.
// slave is the sequencer's view; master is the surrounding system's view.
interface alu_cmd_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [3:0] in_a;
  logic [3:0] in_b;

  logic [2:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_result;
  logic       alu_out;

  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_carry;
  logic [2:0] res_op;

  modport slave (
    input  in_valid, in_op, in_a, in_b, alu_result, alu_out, res_ready,
    output in_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_carry, res_op
  );

  modport master (
    output in_valid, in_op, in_a, in_b, alu_result, alu_out, res_ready,
    input  in_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_carry, res_op
  );
endinterface

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: queues ALU commands in a DEPTH-entry FIFO, issues them one at
// a time to a registered downstream ALU, and returns each result with its
// opcode over a valid/ready handshake, in push order.
// Optional feature: define ALU_CMD_SEQ_STATS_EN to add the 8-bit cmd_count
// output counting completed result handshakes.
module alu_cmd_seq #(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_cmd_seq_if.slave bus
`ifdef ALU_CMD_SEQ_STATS_EN
  ,
  output logic [7:0]   cmd_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t        state;
  state_t        state_next;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          capture;

  cmd_t          cmd;
  logic [3:0]    res_data;
  logic          res_carry;
  logic [2:0]    res_op;

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;

  // FIFO storage; only slots covered by the occupancy count are ever read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
    end
  end

  // FIFO pointers wrap modulo DEPTH; occupancy kept as a separate counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Sequencer next state, FIFO pop and result capture strobes
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        capture    = 1'b1;
        state_next = S_HOLD;
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = S_ISSUE;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command registers load only on pop, so they (and the ALU drive taken from
  // them) hold through ISSUE/WAIT and keep their last value in HOLD/IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cmd <= '0;
    else if (pop) cmd <= mem[rd_ptr];
  end

  // Result capture during WAIT, when the ALU output reflects the issued command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data  <= '0;
      res_carry <= 1'b0;
      res_op    <= '0;
    end else if (capture) begin
      res_data  <= bus.alu_result;
      res_op    <= cmd.op;
      res_carry <= (cmd.op inside {3'b000, 3'b001}) && bus.alu_out;
    end
  end

  assign bus.alu_op    = cmd.op;
  assign bus.alu_a     = cmd.a;
  assign bus.alu_b     = cmd.b;
  assign bus.res_valid = (state == S_HOLD);
  assign bus.res_data  = res_data;
  assign bus.res_carry = res_carry;
  assign bus.res_op    = res_op;

`ifdef ALU_CMD_SEQ_STATS_EN
  logic [7:0] done_count;
  logic       res_fire;

  assign res_fire  = bus.res_valid && bus.res_ready;
  assign cmd_count = done_count;

  // Completed result handshakes, wrapping at 256
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        done_count <= '0;
    else if (res_fire) done_count <= done_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: self-checking bench for alu_cmd_seq with a stub registered
// ALU, a timestamp/queue reference model checked every cycle, directed cases
// with literal expectations and a randomized traffic phase.
// Define ALU_CMD_SEQ_STATS_EN to also check the cmd_count output.
module tb_alu_cmd_seq;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n;

  alu_cmd_seq_if bus ();

`ifdef ALU_CMD_SEQ_STATS_EN
  logic [7:0] cmd_count;
`endif

  alu_cmd_seq #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef ALU_CMD_SEQ_STATS_EN
    ,
    .cmd_count (cmd_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ALU behaviour: {carry, result}
  function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    case (op)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {1'b0, a} + {1'b0, ~b} + 5'd1;
      3'b010:  r = {~^(a ^ b), a & b};
      3'b011:  r = {~^(a ^ b), a | b};
      3'b100:  r = {~^(a ^ b), a ^ b};
      3'b101:  r = {~^(a ^ b), ~a};
      3'b110:  r = {~^(a ^ b), 3'b000, (a > b)};
      default: r = {~^(a ^ b), a + b};
    endcase
    return r;
  endfunction

  // Stub ALU latching its operands on clk
  always @(posedge clk) {bus.alu_out, bus.alu_result} <= alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  // Reference model: queued commands, the one in service and its pop time
  cmd_t        m_fifo[$];
  cmd_t        m_cur;
  cmd_t        m_last;
  bit          m_busy = 1'b0;
  int unsigned t_idx  = 0;
  int unsigned m_pop_t = 0;
  int unsigned m_hs   = 0;

  always @(negedge clk) begin
    logic [4:0] r;
    bit         exp_valid;
    bit         hs;
    bit         acc;
    if (!rst_n) begin
      m_fifo.delete();
      m_busy = 1'b0;
      m_last = '0;
      m_hs   = 0;
      t_idx  = 0;
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_res_data",  32'(bus.res_data),  32'd0);
      chk("rst_res_carry", 32'(bus.res_carry), 32'd0);
      chk("rst_res_op",    32'(bus.res_op),    32'd0);
      chk("rst_alu_op",    32'(bus.alu_op),    32'd0);
      chk("rst_alu_a",     32'(bus.alu_a),     32'd0);
      chk("rst_alu_b",     32'(bus.alu_b),     32'd0);
    end else begin
      t_idx++;
      exp_valid = m_busy && (t_idx >= m_pop_t + 2);
      chk("in_ready",  32'(bus.in_ready),  32'(m_fifo.size() < DEPTH));
      chk("res_valid", 32'(bus.res_valid), 32'(exp_valid));
      chk("alu_op",    32'(bus.alu_op),    32'(m_last.op));
      chk("alu_a",     32'(bus.alu_a),     32'(m_last.a));
      chk("alu_b",     32'(bus.alu_b),     32'(m_last.b));
      if (exp_valid) begin
        r = alu_fn(m_cur.op, m_cur.a, m_cur.b);
        chk("res_data",  32'(bus.res_data),  32'(r[3:0]));
        chk("res_carry", 32'(bus.res_carry), 32'((m_cur.op <= 3'd1) ? r[4] : 1'b0));
        chk("res_op",    32'(bus.res_op),    32'(m_cur.op));
      end
`ifdef ALU_CMD_SEQ_STATS_EN
      chk("cmd_count", 32'(cmd_count), 32'(m_hs % 256));
`endif
      // Effects of the coming clock edge
      hs  = exp_valid && bus.res_ready;
      acc = bus.in_valid && (m_fifo.size() < DEPTH);
      if (hs) begin
        m_hs++;
        m_busy = 1'b0;
      end
      if (!m_busy && m_fifo.size() > 0) begin
        m_cur   = m_fifo.pop_front();
        m_last  = m_cur;
        m_busy  = 1'b1;
        m_pop_t = t_idx + 1;
      end
      if (acc) m_fifo.push_back('{op: bus.in_op, a: bus.in_a, b: bus.in_b});
    end
  end

  task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    chk("push_accepted", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [2:0] op, input logic [3:0] data, input logic carry);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = bus.res_valid;
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({name, "_data"},  32'(bus.res_data),  32'(data));
      chk({name, "_carry"}, 32'(bus.res_carry), 32'(carry));
      chk({name, "_op"},    32'(bus.res_op),    32'(op));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cmd(input string name, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    r = alu_fn(op, a, b);
    expect_result(name, op, r[3:0], (op <= 3'd1) ? r[4] : 1'b0);
  endtask

  task automatic drain();
    bit idle = 1'b0;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 200 && !idle; k++) begin
      @(posedge clk);
      #1;
      idle = !m_busy && (m_fifo.size() == 0);
    end
    chk("drain_idle", 32'(idle), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] bop [6];
    logic [3:0] ba  [6];
    logic [3:0] bb  [6];
    int unsigned n_acc;
    int unsigned stall_pct;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Latency and add with carry: 7 + 9 = 16 -> data 0, carry 1
    bus.res_ready = 1'b1;
    push(3'b000, 4'd7, 4'd9);
    @(negedge clk); chk("lat_n0", 32'(bus.res_valid), 32'd0);
    @(negedge clk); chk("lat_n1", 32'(bus.res_valid), 32'd0);
    @(negedge clk); chk("lat_n2", 32'(bus.res_valid), 32'd0);
    @(negedge clk); chk("lat_n3", 32'(bus.res_valid), 32'd1);
    chk("add_data",  32'(bus.res_data),  32'h0);
    chk("add_carry", 32'(bus.res_carry), 32'd1);
    chk("add_op",    32'(bus.res_op),    32'd0);
    @(posedge clk);
    #1;

    // Subtract 3 - 5 = 0xE with carry 0; compare op with carry forced to 0
    push(3'b001, 4'd3, 4'd5);
    expect_result("sub", 3'b001, 4'hE, 1'b0);
    push(3'b110, 4'd8, 4'd1);
    expect_result("op6", 3'b110, 4'h1, 1'b0);

    // HOLD stability for 10 cycles: 0xC & 0xA = 8, carry masked
    bus.res_ready = 1'b0;
    push(3'b010, 4'hC, 4'hA);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        seen = bus.res_valid;
      end
      chk("hold_seen", 32'(seen), 32'd1);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_data",  32'(bus.res_data),  32'h8);
      chk("hold_carry", 32'(bus.res_carry), 32'd0);
      chk("hold_op",    32'(bus.res_op),    32'd2);
    end
    drain();

    // Capacity: six back-to-back commands with results stalled, five accepted
    bus.res_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      bop[i] = 3'(i);
      ba[i]  = 4'(i + 1);
      bb[i]  = 4'(2 * i);
      bus.in_valid = 1'b1;
      bus.in_op    = bop[i];
      bus.in_a     = ba[i];
      bus.in_b     = bb[i];
      @(negedge clk);
      if (bus.in_ready) n_acc++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("bb_accepted", 32'(n_acc), 32'd5);
    @(negedge clk);
    chk("bb_full", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) expect_cmd("bb", bop[i], ba[i], bb[i]);
    @(negedge clk);
    chk("bb_ready_back", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Reset while WAIT with two commands queued
    push(3'b011, 4'd5, 4'd3);
    push(3'b100, 4'd6, 4'd6);
    push(3'b101, 4'd9, 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("arst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("arst_res_data",  32'(bus.res_data),  32'd0);
    chk("arst_res_carry", 32'(bus.res_carry), 32'd0);
    chk("arst_res_op",    32'(bus.res_op),    32'd0);
    chk("arst_alu_op",    32'(bus.alu_op),    32'd0);
    chk("arst_alu_a",     32'(bus.alu_a),     32'd0);
    chk("arst_alu_b",     32'(bus.alu_b),     32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(bus.res_valid), 32'd0);
    end
    @(posedge clk);
    #1;

`ifdef ALU_CMD_SEQ_STATS_EN
    for (int i = 0; i < 256; i++) begin
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      op = 3'($urandom_range(0, 7));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      push(op, a, b);
      expect_cmd("stats", op, a, b);
      if (i == 2)   chk("stats_3",   32'(cmd_count), 32'd3);
      if (i == 255) chk("stats_256", 32'(cmd_count), 32'd0);
    end
`endif

    // Randomized traffic with alternating light and heavy result back-pressure
    stall_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) stall_pct = (stall_pct == 80) ? 20 : 80;
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.in_op     = 3'($urandom_range(0, 7));
      bus.in_a      = 4'($urandom_range(0, 15));
      bus.in_b      = 4'($urandom_range(0, 15));
      bus.res_ready = ($urandom_range(0, 99) >= stall_pct);
      @(posedge clk);
      #1;
    end
    drain();
    repeat (5) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
